seg7_ctrl: RTL and testbench

Output-side display peripheral for the Nexys4 board: it is the write counterpart of the switch-sampling input register. On `start_port`, it captures a 32-bit value plus per-digit enable and decimal-point masks from the accelerator. It then continuously time-multiplexes the eight-digit seven-segment display: hex decode, anode scan and anti-ghost blanking. It acknowledges each capture with a one-cycle `done_port` pulse.

---
 rtl/seg7_ctrl_if.sv | 22 ++
 rtl/seg7_ctrl.sv | 107 ++++++++++
 tb/tb_seg7_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seg7_ctrl_if.sv
// Capture/acknowledge bus plus the display pins of the seven-segment controller.
// The accelerator side (master) drives the capture strobe and data; the controller (slave) drives the pins.
interface seg7_ctrl_if;
    logic        start_port;
    logic [31:0] in1;
    logic [7:0]  in2;
    logic [7:0]  in3;
    logic        done_port;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output start_port, in1, in2, in3,
        input  done_port, an, seg, dp
    );

    modport slave (
        input  start_port, in1, in2, in3,
        output done_port, an, seg, dp
    );
endinterface

// File: rtl/seg7_ctrl.sv
// Eight-digit seven-segment display controller: captures value/enable/dp masks on a strobe
// and time-multiplexes the digits with a dark window at the start of every slot.
module seg7_ctrl #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic        clock,
    input  logic        reset,
    seg7_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [31:0]      val_q, val_d;
    logic [7:0]       en_q, en_d;
    logic [7:0]       dpm_q, dpm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        val_d  = val_q;
        en_d   = en_q;
        dpm_d  = dpm_q;
        done_d = bus.start_port;
        if (bus.start_port) begin
            val_d = bus.in1;
            en_d  = bus.in2;
            dpm_d = bus.in3;
        end

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end

        // Outputs follow the current counter/index and shadow, so they lag them by one cycle.
        nib   = val_q[{idx_q, 2'b00} +: 4];
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (cnt_q >= CNT_BLANK && en_q[idx_q]) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex_to_seg(nib);
            dp_d  = ~dpm_q[idx_q];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            val_q  <= '0;
            en_q   <= '0;
            dpm_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            an_q   <= 8'hFF;
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
        end else begin
            val_q  <= val_d;
            en_q   <= en_d;
            dpm_q  <= dpm_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            done_q <= done_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign bus.done_port = done_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
endmodule

// File: tb/tb_seg7_ctrl.sv
// Directed bench for seg7_ctrl with REFRESH_CYCLES=8, BLANK_CYCLES=2.
// ecnt counts clock edges since reset release; outputs seen at edge count k follow slot position k-1.
module tb_seg7_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   ecnt;
    int   n_checks = 0;
    int   n_pass   = 0;

    seg7_ctrl_if bus();

    seg7_ctrl #(.REFRESH_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    localparam logic [7:0] S2_AN  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    localparam logic [6:0] S2_SEG [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    localparam logic [7:0] S3_AN  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [6:0] S3_SEG [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic       S3_DP  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    function automatic logic [31:0] pk(input logic d, input logic [7:0] a, input logic [6:0] s, input logic p);
        return {15'd0, d, a, s, p};
    endfunction

    function automatic logic [31:0] obs();
        return pk(bus.done_port, bus.an, bus.seg, bus.dp);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_k(input int target);
        int guard = 0;
        while (ecnt != target && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        if (ecnt != target) chk("wait_timeout", ecnt, target);
    endtask

    task automatic dark_run(input string tag);
        for (int i = 0; i < 64; i++) begin
            wait_k(i);
            chk(tag, obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
        end
    endtask

    initial begin
        bus.start_port = 1'b0;
        bus.in1 = '0;
        bus.in2 = '0;
        bus.in3 = '0;
        repeat (3) @(negedge clock);
        chk("reset_state", obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
        reset = 1'b1;

        // 1: idle after reset
        dark_run("idle_dark");

        // 2: single capture, full hex frame
        wait_k(64);
        bus.start_port = 1'b1;
        bus.in1 = 32'h89ABCDEF;
        bus.in2 = 8'hFF;
        bus.in3 = 8'h00;
        wait_k(65);
        bus.start_port = 1'b0;
        chk("s2_done_hi", {31'd0, bus.done_port}, 32'd1);
        wait_k(66);
        chk("s2_done_lo", {31'd0, bus.done_port}, 32'd0);
        for (int d = 0; d < 8; d++) begin
            wait_k(129 + 8 * d);
            chk($sformatf("s2_blank_d%0d", d), obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
            wait_k(130 + 8 * d);
            chk($sformatf("s2_blank2_d%0d", d), obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
            wait_k(131 + 8 * d);
            chk($sformatf("s2_first_d%0d", d), obs(), pk(1'b0, S2_AN[d], S2_SEG[d], 1'b1));
            wait_k(136 + 8 * d);
            chk($sformatf("s2_last_d%0d", d), obs(), pk(1'b0, S2_AN[d], S2_SEG[d], 1'b1));
        end

        // 3: partial enable and dp mask
        wait_k(200);
        bus.start_port = 1'b1;
        bus.in1 = 32'h01234567;
        bus.in2 = 8'h0F;
        bus.in3 = 8'h05;
        wait_k(201);
        bus.start_port = 1'b0;
        for (int d = 0; d < 8; d++) begin
            wait_k(257 + 8 * d);
            chk($sformatf("s3_blank_d%0d", d), obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
            wait_k(259 + 8 * d);
            chk($sformatf("s3_first_d%0d", d), obs(), pk(1'b0, S3_AN[d], S3_SEG[d], S3_DP[d]));
            wait_k(264 + 8 * d);
            chk($sformatf("s3_last_d%0d", d), obs(), pk(1'b0, S3_AN[d], S3_SEG[d], S3_DP[d]));
        end

        // 4: start held three cycles while digit 0 is lit
        wait_k(385);
        bus.start_port = 1'b1;
        bus.in1 = 32'd1;
        bus.in2 = 8'h01;
        bus.in3 = 8'h00;
        wait_k(386);
        chk("s4_done1", {31'd0, bus.done_port}, 32'd1);
        bus.in1 = 32'd2;
        wait_k(387);
        chk("s4_show1", obs(), pk(1'b1, 8'hFE, 7'h79, 1'b1));
        bus.in1 = 32'd3;
        wait_k(388);
        chk("s4_show2", obs(), pk(1'b1, 8'hFE, 7'h24, 1'b1));
        bus.start_port = 1'b0;
        wait_k(389);
        chk("s4_show3", obs(), pk(1'b0, 8'hFE, 7'h30, 1'b1));
        wait_k(392);
        chk("s4_hold3", obs(), pk(1'b0, 8'hFE, 7'h30, 1'b1));
        wait_k(393);
        chk("s4_next_blank", obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
        wait_k(451);
        chk("s4_next_frame", obs(), pk(1'b0, 8'hFE, 7'h30, 1'b1));

        // 5: reset while digit 5 is lit
        wait_k(460);
        bus.start_port = 1'b1;
        bus.in1 = 32'h89ABCDEF;
        bus.in2 = 8'hFF;
        bus.in3 = 8'hFF;
        wait_k(461);
        bus.start_port = 1'b0;
        wait_k(557);
        chk("s5_lit_d5", obs(), pk(1'b0, 8'hDF, 7'h08, 1'b0));
        reset = 1'b0;
        #1;
        chk("s5_async_rst", obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
        @(negedge clock);
        reset = 1'b1;
        dark_run("s5_dark_after");

        // 6: capture on a counter wrap
        wait_k(71);
        bus.start_port = 1'b1;
        bus.in1 = 32'h76543210;
        bus.in2 = 8'hFF;
        bus.in3 = 8'h00;
        wait_k(72);
        bus.start_port = 1'b0;
        chk("s6_done_blank", obs(), pk(1'b1, 8'hFF, 7'h7F, 1'b1));
        wait_k(73);
        chk("s6_blank1", obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
        wait_k(74);
        chk("s6_blank2", obs(), pk(1'b0, 8'hFF, 7'h7F, 1'b1));
        wait_k(75);
        chk("s6_first_lit", obs(), pk(1'b0, 8'hFD, 7'h79, 1'b1));
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            chk("s6_one_anode", {31'd0, ($countones(~bus.an) <= 1)}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
